ofdm_rx_bit_packer: RTL and testbench

Downstream of the OFDM RX top level. Consumes the 2-bit demapped stream (rx_rcv_data / rx_rcv_data_valid) and packs it MSB-first into out_width_g-bit words. Words go into a first-word-fall-through FIFO with a valid/ready output and OFDM-symbol-boundary marking. On FIFO overflow it drops the rest of the damaged OFDM symbol and resynchronises at the next symbol start.

---
 rtl/ofdm_rx_bit_packer.sv | 164 ++++++++++++++++
 tb/tb_ofdm_rx_bit_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_rx_bit_packer.sv
// Packs the 2-bit demapped OFDM RX stream MSB-first into words and queues them in a FWFT FIFO.
// Optional statistics outputs (word_cnt, drop_cnt) are enabled by defining OFDM_RX_PACKER_STATS_EN.
module ofdm_rx_bit_packer #(
   parameter int raw_symbol_length_g = 64,
   parameter int out_width_g         = 8,
   parameter int fifo_depth_g        = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   sys_init,
   input  logic [1:0]             rx_rcv_data,
   input  logic                   rx_rcv_data_valid,
   output logic [out_width_g-1:0] word_data,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic                   word_last,
   output logic                   overflow,
   output logic [15:0]            symbol_cnt
`ifdef OFDM_RX_PACKER_STATS_EN
   ,
   output logic [31:0]            word_cnt,
   output logic [15:0]            drop_cnt
`endif
);

   // state    | meaning
   // ST_IDLE  | waiting for the first pair after reset/init
   // ST_PACK  | packing pairs and writing completed words to the FIFO
   // ST_DISCARD | dropping the rest of a symbol that overflowed

   localparam int PAIRS = raw_symbol_length_g / 2;
   localparam int BEATS = out_width_g / 2;
   localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW    = $clog2(fifo_depth_g);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PACK    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          pair_cnt_q, pair_cnt_d;
   logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
   logic [out_width_g-1:0] sr_q, sr_d;
   logic                   overflow_q, overflow_d;
   logic [15:0]            symbol_cnt_q, symbol_cnt_d;
   logic [AW:0]            wr_ptr_q, wr_ptr_d;
   logic [AW:0]            rd_ptr_q, rd_ptr_d;
   logic [out_width_g:0]   mem_q [fifo_depth_g];

   logic                   clr;
   logic [out_width_g-1:0] word_next;
   logic                   pair_end, beat_end, word_done;
   logic [AW:0]            fill;
   logic                   full, empty, pop, push, drop, packing;
   logic [out_width_g:0]   head;

   assign clr       = sys_rst | sys_init;
   assign word_next = (sr_q << 2) | out_width_g'(rx_rcv_data);
   assign pair_end  = (pair_cnt_q == PW'(PAIRS - 1));
   assign beat_end  = (beat_cnt_q == BW'(BEATS - 1));
   assign word_done = rx_rcv_data_valid & beat_end;

   assign fill    = wr_ptr_q - rd_ptr_q;
   assign full    = (fill == (AW+1)'(fifo_depth_g));
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign pop     = ~empty & word_ready;
   assign packing = (state_q != ST_DISCARD);
   assign push    = packing & word_done & (~full | pop);
   assign drop    = packing & word_done & full & ~pop;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_PACK: begin
            if (rx_rcv_data_valid) state_d = ST_PACK;
            // a dropped last word needs no resync: the next pair already starts a symbol
            if (drop && !pair_end) state_d = ST_DISCARD;
         end
         ST_DISCARD: begin
            if (rx_rcv_data_valid && pair_end) state_d = ST_PACK;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pair_cnt_d   = pair_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      sr_d         = sr_q;
      overflow_d   = overflow_q | drop;
      symbol_cnt_d = symbol_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (rx_rcv_data_valid) begin
         pair_cnt_d = pair_end ? '0 : pair_cnt_q + 1'b1;
         beat_cnt_d = beat_end ? '0 : beat_cnt_q + 1'b1;
         sr_d       = word_next;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (pair_end) symbol_cnt_d = symbol_cnt_q + 16'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         pair_cnt_q   <= '0;
         beat_cnt_q   <= '0;
         sr_q         <= '0;
         overflow_q   <= 1'b0;
         symbol_cnt_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         pair_cnt_q   <= pair_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         sr_q         <= sr_d;
         overflow_q   <= overflow_d;
         symbol_cnt_q <= symbol_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= {word_next, pair_end};
   end

   // storage is not reset, so the head is masked while the FIFO is empty
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign word_valid = ~empty;
   assign word_data  = empty ? '0 : head[out_width_g:1];
   assign word_last  = ~empty & head[0];
   assign overflow   = overflow_q;
   assign symbol_cnt = symbol_cnt_q;

`ifdef OFDM_RX_PACKER_STATS_EN
   logic [31:0] word_cnt_q;
   logic [15:0] drop_cnt_q;
   logic        drop_evt;

   assign drop_evt = word_done & (drop | (state_q == ST_DISCARD));

   always_ff @(posedge sys_clk) begin
      if (clr) begin
         word_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push) word_cnt_q <= word_cnt_q + 32'd1;
         if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign word_cnt = word_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ofdm_rx_bit_packer.sv
// Directed bench for ofdm_rx_bit_packer with a word scoreboard checked at every output transfer.
module tb_ofdm_rx_bit_packer;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       sys_init = 1'b0;
   logic [1:0] rx_rcv_data = 2'b00;
   logic       rx_rcv_data_valid = 1'b0;
   logic [7:0] word_data;
   logic       word_valid;
   logic       word_ready = 1'b0;
   logic       word_last;
   logic       overflow;
   logic [15:0] symbol_cnt;
`ifdef OFDM_RX_PACKER_STATS_EN
   logic [31:0] word_cnt;
   logic [15:0] drop_cnt;
`endif

   int compared = 0;
   int mismatched = 0;
   int xfer_cnt = 0;
   logic [8:0] exp_q [$];

   always #5 sys_clk = ~sys_clk;

   ofdm_rx_bit_packer #(
      .raw_symbol_length_g(64),
      .out_width_g(8),
      .fifo_depth_g(16)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .sys_init(sys_init),
      .rx_rcv_data(rx_rcv_data),
      .rx_rcv_data_valid(rx_rcv_data_valid),
      .word_data(word_data),
      .word_valid(word_valid),
      .word_ready(word_ready),
      .word_last(word_last),
      .overflow(overflow),
      .symbol_cnt(symbol_cnt)
`ifdef OFDM_RX_PACKER_STATS_EN
      ,
      .word_cnt(word_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // a transfer happens at the next rising edge whenever valid and ready are seen mid-cycle
   always @(negedge sys_clk) begin
      if (word_valid && word_ready) begin
         xfer_cnt++;
         check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("word_data", 32'(word_data), 32'(e[8:1]));
            check("word_last", 32'(word_last), 32'(e[0]));
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      word_ready = 1'b0;
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit last, input bit expect_out, input bit pop_last);
      if (expect_out) exp_q.push_back({w, last});
      for (int i = 0; i < 4; i++) begin
         rx_rcv_data = w[7-2*i -: 2];
         rx_rcv_data_valid = 1'b1;
         if (pop_last && i == 3) word_ready = 1'b1;
         tick();
      end
      rx_rcv_data_valid = 1'b0;
      if (pop_last) word_ready = 1'b0;
   endtask

   task automatic send_symbol(input logic [7:0] base, input bit expect_out);
      for (int k = 0; k < 8; k++)
         send_word(base ^ 8'(k * 8'h37), k == 7, expect_out, 1'b0);
   endtask

   task automatic drain(input int budget);
      word_ready = 1'b1;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      tick();
      check("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int x0;
      tick();
      do_reset();
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_word_data", 32'(word_data), 32'd0);
      check("rst_word_last", 32'(word_last), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_symbol_cnt", 32'(symbol_cnt), 32'd0);

      // scenario 1: 32 pairs of 2'b10 -> eight 0xAA words
      word_ready = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back({8'hAA, k == 7});
      for (int i = 0; i < 32; i++) begin
         rx_rcv_data = 2'b10;
         rx_rcv_data_valid = 1'b1;
         tick();
         if (i == 2) check("s1_valid_before_word", 32'(word_valid), 32'd0);
         if (i == 3) check("s1_valid_after_word", 32'(word_valid), 32'd1);
      end
      rx_rcv_data_valid = 1'b0;
      drain(20);
      check("s1_symbol_cnt", 32'(symbol_cnt), 32'd1);

      // scenario 2: MSB-first ordering, then the rest of the symbol
      send_word(8'hC6, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k < 8; k++) send_word(8'h5C + 8'(k * 13), k == 7, 1'b1, 1'b0);
      drain(20);
      check("s2_symbol_cnt", 32'(symbol_cnt), 32'd2);

      // scenario 3: overflow with consumer stalled
      do_reset();
      send_symbol(8'h11, 1'b1);
      send_symbol(8'h42, 1'b1);
      check("s3_no_overflow_at_full", 32'(overflow), 32'd0);
      send_symbol(8'h93, 1'b0);
      tick();
      check("s3_overflow", 32'(overflow), 32'd1);
      check("s3_symbol_cnt", 32'(symbol_cnt), 32'd2);
      check("s3_valid_held", 32'(word_valid), 32'd1);
`ifdef OFDM_RX_PACKER_STATS_EN
      check("s6_word_cnt", word_cnt, 32'd16);
      check("s6_drop_cnt", 32'(drop_cnt), 32'd8);
`endif
      drain(40);
      word_ready = 1'b1;
      send_symbol(8'hE7, 1'b1);
      drain(20);
      check("s3_symbol_cnt_after", 32'(symbol_cnt), 32'd3);
      check("s3_overflow_sticky", 32'(overflow), 32'd1);

      // scenario 4: word completes on a full FIFO together with a pop
      do_reset();
      send_symbol(8'h24, 1'b1);
      send_symbol(8'h6B, 1'b1);
      send_word(8'h3D, 1'b0, 1'b1, 1'b1);
      tick();
      check("s4_overflow", 32'(overflow), 32'd0);
      x0 = xfer_cnt;
      drain(40);
      check("s4_fill_level", 32'(xfer_cnt - x0), 32'd16);
      word_ready = 1'b1;
      for (int k = 1; k < 8; k++) send_word(8'hA0 + 8'(k), k == 7, 1'b1, 1'b0);
      drain(20);
      check("s4_symbol_cnt", 32'(symbol_cnt), 32'd3);
      check("s4_overflow_end", 32'(overflow), 32'd0);

      // scenario 5: sys_init mid-symbol with words queued, colliding with a valid pair
      do_reset();
      send_word(8'h77, 1'b0, 1'b0, 1'b0);
      send_word(8'h88, 1'b0, 1'b0, 1'b0);
      rx_rcv_data = 2'b01;
      rx_rcv_data_valid = 1'b1;
      tick();
      rx_rcv_data = 2'b11;
      sys_init = 1'b1;
      tick();
      sys_init = 1'b0;
      rx_rcv_data_valid = 1'b0;
      check("s5_valid_after_init", 32'(word_valid), 32'd0);
      check("s5_data_after_init", 32'(word_data), 32'd0);
      check("s5_symbol_cnt", 32'(symbol_cnt), 32'd0);
      check("s5_overflow", 32'(overflow), 32'd0);
      word_ready = 1'b1;
      send_word(8'h1B, 1'b0, 1'b1, 1'b0);
      send_word(8'hE4, 1'b0, 1'b1, 1'b0);
      send_word(8'h5A, 1'b0, 1'b1, 1'b0);
      send_word(8'h3C, 1'b0, 1'b1, 1'b0);
      drain(20);
      check("s5_symbol_cnt_end", 32'(symbol_cnt), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
